avalon_ram_slave: RTL and testbench

// - Avalon-MM memory slave on the far side of the CPU's bus master; serves instruction fetches and loads/stores.
// - Word-wide RAM with two address windows (boot and data), byteenable writes and configurable wait states.
// - Flags illegal accesses on a sticky error output.
// - Used as the CPU's memory in system simulation and as the on-chip RAM in synthesis.

---
 rtl/avalon_ram_slave.sv | 144 ++++++++++++++
 tb/tb_avalon_ram_slave.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_ram_slave.sv
// Avalon-MM word RAM slave with boot and data windows, byteenable writes, wait states and a sticky error flag.
// Define AVALON_RAM_RANDOM_STALL_EN to add 0..3 pseudo-random extra wait cycles per request.
module avalon_ram_slave #(
    parameter int          ADDR_BITS   = 10,
    parameter logic [31:0] BOOT_BASE   = 32'hBFC00000,
    parameter logic [31:0] DATA_BASE   = 32'h00000000,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic [31:0] readdata,
    output logic        bus_error
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    logic [31:0] boot_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] readdata_q, readdata_d;
    logic        bus_error_q, bus_error_d;
    logic [4:0]  stall;
    logic        req, access, illegal;

    // Word offsets into each window; a base above the address underflows
    // into the upper bits and so reads as a miss.
    logic [30:0]          boot_off, data_off;
    logic                 hit_boot, hit_data;
    logic [ADDR_BITS-1:0] idx;

    assign boot_off = {1'b0, address[31:2]} - {1'b0, BOOT_BASE[31:2]};
    assign data_off = {1'b0, address[31:2]} - {1'b0, DATA_BASE[31:2]};
    assign hit_boot = (boot_off[30:ADDR_BITS] == '0);
    assign hit_data = (data_off[30:ADDR_BITS] == '0);
    assign idx      = hit_boot ? boot_off[ADDR_BITS-1:0] : data_off[ADDR_BITS-1:0];

    assign req     = read | write;
    assign illegal = (address[1:0] != 2'b00) | ~(hit_boot | hit_data) | (read & write);

`ifdef AVALON_RAM_RANDOM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign stall = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
    assign stall = 5'(WAIT_CYCLES);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        readdata_d  = readdata_q;
        bus_error_d = bus_error_q;
        access      = 1'b0;
`ifdef AVALON_RAM_RANDOM_STALL_EN
        lfsr_d      = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req) begin
`ifdef AVALON_RAM_RANDOM_STALL_EN
                    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
                    if (stall == 5'd0) begin
                        state_d = ACK;
                        access  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = stall;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    // master withdrew before acceptance
                    state_d     = IDLE;
                    bus_error_d = 1'b1;
                end else if (cnt_q == 5'd1) begin
                    state_d = ACK;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (access) begin
            if (illegal) begin
                readdata_d  = 32'h0;
                bus_error_d = 1'b1;
            end else if (read) begin
                readdata_d = hit_boot ? boot_mem[idx] : data_mem[idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            readdata_q  <= 32'h0;
            bus_error_q <= 1'b0;
`ifdef AVALON_RAM_RANDOM_STALL_EN
            lfsr_q      <= 8'hA5;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            readdata_q  <= readdata_d;
            bus_error_q <= bus_error_d;
`ifdef AVALON_RAM_RANDOM_STALL_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    logic mem_we, boot_we, data_we;
    assign mem_we  = access & write & ~illegal & ~reset;
    assign boot_we = mem_we & hit_boot;
    assign data_we = mem_we & ~hit_boot;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (boot_we && byteenable[b]) boot_mem[idx][8*b +: 8] <= writedata[8*b +: 8];
            if (data_we && byteenable[b]) data_mem[idx][8*b +: 8] <= writedata[8*b +: 8];
        end
    end

    assign waitrequest = reset | (req & (state_q != ACK));
    assign readdata    = readdata_q;
    assign bus_error   = bus_error_q;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Scoreboard bench: a word-addressed reference memory predicts read data and the error flag.
module tb_avalon_ram_slave;
    localparam logic [31:0] BOOT = 32'hBFC00000;
    localparam int WSIZE = 4096;

    logic clk = 0, reset = 1;
    logic [31:0] address = 0, writedata = 0, readdata;
    logic read = 0, write = 0, waitrequest, bus_error;
    logic [3:0] byteenable = 0;
    logic [31:0] address_1 = 0, writedata_1 = 0, readdata_1;
    logic read_1 = 0, write_1 = 0, waitrequest_1, bus_error_1;
    logic [3:0] byteenable_1 = 0;

    avalon_ram_slave #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable), .waitrequest(waitrequest),
        .readdata(readdata), .bus_error(bus_error));

    avalon_ram_slave #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset(reset), .address(address_1), .read(read_1), .write(write_1),
        .writedata(writedata_1), .byteenable(byteenable_1), .waitrequest(waitrequest_1),
        .readdata(readdata_1), .bus_error(bus_error_1));

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    logic [31:0] q0[$], q1[$];
    logic [31:0] mem_m [logic [31:0]];
    logic exp_berr = 0;
    logic [31:0] pool [16];
    int lat1 [64];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic bit legal(input logic [31:0] a, input bit rd, input bit wr);
        longint ua = a;
        bit inb = (ua >= longint'(BOOT)) && (ua < longint'(BOOT) + WSIZE);
        bit ind = ua < WSIZE;
        return (a % 4 == 0) && (inb || ind) && !(rd && wr);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Monitor: every accepted read is matched against the oldest prediction.
    always @(negedge clk) begin
        if (!reset && read && !waitrequest) begin
            if (q0.size() == 0) begin n_chk++; $display("FAIL ack0: unexpected read ack, readdata %h", readdata); end
            else chk("rdata0", readdata, q0.pop_front());
        end
        if (!reset && read_1 && !waitrequest_1) begin
            if (q1.size() == 0) begin n_chk++; $display("FAIL ack1: unexpected read ack, readdata %h", readdata_1); end
            else chk("rdata1", readdata_1, q1.pop_front());
        end
    end

    // Called and returns at posedge+1.
    task automatic bus_op(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, input logic [3:0] be, output int hi);
        bit ok = legal(a, rd, wr);
        bit done = 0;
        hi = 0;
        address = a; read = rd; write = wr; writedata = wd; byteenable = be;
        if (rd) q0.push_back(!ok ? 32'h0 : (mem_m.exists(a) ? mem_m[a] : 32'hx));
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (waitrequest) hi++; else done = 1;
        end
        if (!done) begin n_chk++; $display("FAIL timeout: no ack for addr %h", a); end
        @(posedge clk); #1;
        read = 0; write = 0;
        if (wr && ok) mem_m[a] = merge(mem_m.exists(a) ? mem_m[a] : 32'h0, wd, be);
        if (!ok) exp_berr = 1;
`ifdef AVALON_RAM_RANDOM_STALL_EN
        chk("latency", 32'(hi >= 2 && hi <= 5), 32'd1);
`else
        chk("latency", 32'(hi), 32'd2);
`endif
        chk("bus_error", 32'(bus_error), 32'(exp_berr));
    endtask

    task automatic do_reset();
        reset = 1; read = 0; write = 0; read_1 = 0; write_1 = 0;
        @(negedge clk);
        chk("wait_in_reset", 32'(waitrequest), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rdata_reset", readdata, 32'h0);
        chk("berr_reset", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        reset = 0;
        exp_berr = 0;
    endtask

    initial begin
        int hi, r, tot;
        logic [31:0] a, d;
        bit done;

        do_reset();

        // boot reset vector word
        bus_op(BOOT, 0, 1, 32'h24020005, 4'hF, hi);
        bus_op(BOOT, 1, 0, 0, 0, hi);
        chk("boot_lat", 32'(hi >= 2), 32'd1);

        // byteenable merge
        bus_op(32'h10, 0, 1, 32'hAABBCCDD, 4'b1111, hi);
        bus_op(32'h10, 0, 1, 32'h11223344, 4'b0101, hi);
        bus_op(32'h10, 1, 0, 0, 0, hi);
        chk("merge_model", mem_m[32'h10], 32'hAA22CC44);
        bus_op(32'h10, 0, 1, 32'hFFFFFFFF, 4'b0000, hi);
        bus_op(32'h10, 1, 0, 0, 0, hi);

        // top-of-window words in both windows
        bus_op(32'h00000FFC, 0, 1, 32'hCAFEF00D, 4'hF, hi);
        bus_op(BOOT + 32'hFFC, 0, 1, 32'h0BADBEEF, 4'hF, hi);
        bus_op(32'h00000FFC, 1, 0, 0, 0, hi);
        bus_op(BOOT + 32'hFFC, 1, 0, 0, 0, hi);

        // randomized legal traffic over a preloaded pool
        for (int i = 0; i < 8; i++) begin
            pool[i]     = 32'($urandom_range(0, 1023)) << 2;
            pool[8 + i] = BOOT + (32'($urandom_range(0, 1023)) << 2);
        end
        foreach (pool[i]) bus_op(pool[i], 0, 1, $urandom, 4'hF, hi);
        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 15)];
            if (r < 6) bus_op(a, 1, 0, 0, 0, hi);
            else       bus_op(a, 0, 1, $urandom, 4'($urandom_range(0, 15)), hi);
        end

        // reset during the wait of a write discards it
        bus_op(32'h20, 0, 1, 32'h12345678, 4'hF, hi);
        address = 32'h20; writedata = 32'hDEADBEEF; byteenable = 4'hF; write = 1;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("wait_reset_mid", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        write = 0;
        @(posedge clk); #1;
        reset = 0; exp_berr = 0;
        bus_op(32'h20, 1, 0, 0, 0, hi);

        // illegal accesses: handshake, zero data, sticky error, no write
        bus_op(32'h00000003, 1, 0, 0, 0, hi);
        chk("berr_sticky", 32'(bus_error), 32'd1);
        bus_op(32'h40000000, 1, 0, 0, 0, hi);
        bus_op(32'h00001000, 1, 0, 0, 0, hi);
        bus_op(BOOT + 32'h1000, 0, 1, 32'h55555555, 4'hF, hi);
        bus_op(32'h10, 1, 1, 32'h77777777, 4'hF, hi);
        bus_op(32'h12, 0, 1, 32'h66666666, 4'hF, hi);
        bus_op(32'h10, 1, 0, 0, 0, hi);
        bus_op(BOOT, 1, 0, 0, 0, hi);
        chk("berr_still", 32'(bus_error), 32'd1);

        // master drops read during wait
        do_reset();
        address = pool[0]; read = 1;
        @(posedge clk); #1;
        read = 0;
        @(posedge clk); #1;
        chk("abort_berr", 32'(bus_error), 32'd1);
        chk("abort_rdata", readdata, 32'h0);
        exp_berr = 1;
        bus_op(pool[1], 1, 0, 0, 0, hi);

        // latency sequence is reproducible from reset
        do_reset();
        for (int i = 0; i < 64; i++) begin bus_op(pool[i % 16], 1, 0, 0, 0, hi); lat1[i] = hi; end
        do_reset();
        for (int i = 0; i < 64; i++) begin
            bus_op(pool[i % 16], 1, 0, 0, 0, hi);
            chk("lat_repeat", 32'(hi), 32'(lat1[i]));
        end

        // zero-wait instance: back-to-back reads
        for (int i = 0; i < 4; i++) begin
            d = $urandom;
            address_1 = 32'h100 + 32'(4 * i); writedata_1 = d; byteenable_1 = 4'hF; write_1 = 1;
            q1.push_back(d);
            done = 0;
            for (int k = 0; k < 20 && !done; k++) begin @(negedge clk); if (!waitrequest_1) done = 1; end
            if (!done) begin n_chk++; $display("FAIL timeout1: write %0d not acked", i); end
            @(posedge clk); #1;
        end
        write_1 = 0;
        tot = 0;
        read_1 = 1;
        for (int i = 0; i < 4; i++) begin
            address_1 = 32'h100 + 32'(4 * i);
            hi = 0; done = 0;
            for (int k = 0; k < 20 && !done; k++) begin
                @(negedge clk); tot++;
                if (waitrequest_1) hi++; else done = 1;
            end
`ifdef AVALON_RAM_RANDOM_STALL_EN
            chk("b2b_hi", 32'(hi >= 1 && hi <= 4), 32'd1);
`else
            chk("b2b_hi", 32'(hi), 32'd1);
`endif
            @(posedge clk); #1;
        end
        read_1 = 0;
`ifndef AVALON_RAM_RANDOM_STALL_EN
        chk("b2b_total", 32'(tot), 32'd8);
`endif
        chk("berr_w0", 32'(bus_error_1), 32'd0);

        repeat (2) @(posedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
